pc_fetch_unit: RTL

//  Program-counter register and fetch sequencer of the single-cycle CPU, directly downstream of the

---
 rtl/pc_fetch_unit.sv | 85 ++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter register and fetch/exec/halt sequencer
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [31:0] nextPC,
    input  logic [5:0]  opcode,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] curPC,
    output logic [31:0] pcPlus4,
    output logic        instr_valid,
    output logic        halted,
    output logic        misalign,
    output logic [31:0] retire_cnt
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        misalign_q, misalign_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // HALT wins over a simultaneous retire request
                if (opcode == HALT_OPCODE) begin
                    state_d = ST_HALT;
                end else if (PCWre) begin
                    pc_d       = {nextPC[31:2], 2'b00};
                    cnt_d      = cnt_q + 32'd1;
                    misalign_d = (nextPC[1:0] != 2'b00);
                    state_d    = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            cnt_q      <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign instr_valid = (state_q == ST_EXEC);
    assign halted      = (state_q == ST_HALT);
    assign misalign    = misalign_q;
    assign curPC       = pc_q;
    assign pcPlus4     = pc_q + 32'd4;
    assign retire_cnt  = cnt_q;

endmodule
